// File: rtl/clk_sw_pkg.sv
// clk_sw_pkg: shared state encoding, one-hot decode and parameter range check for the clock-switch controller
package clk_sw_pkg;
  localparam int MAXN = 16;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_PARK = 2'd2} state_t;
  function automatic logic [MAXN-1:0] onehot(input logic [3:0] sel);
    return 16'd1 << sel;
  endfunction
  function automatic bit params_ok(input int n, input int dead, input int rst_sel);
    return n >= 2 && n <= MAXN && dead >= 1 && rst_sel >= 0 && rst_sel < n;
  endfunction
endpackage

// File: rtl/clk_sw_deadcnt.sv
// clk_sw_deadcnt: loadable dead-time down-counter (clk, rst, i_load, i_dec -> o_done on the final decrement)
module clk_sw_deadcnt #(
  parameter int DEAD_CYCLES = 2,
  localparam int CW = $clog2(DEAD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= CW'(DEAD_CYCLES);
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == CW'(1);
endmodule

// File: rtl/clk_sw_ctrl.sv
// clk_sw_ctrl: N-channel break-before-make clock-enable switch (sel_valid/sel_req/sel_park in; sel_ready, en_o, cur_sel, parked, busy, err out)
module clk_sw_ctrl
  import clk_sw_pkg::*;
#(
  parameter int N = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int RST_SEL = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel_valid,
  input  logic [SELW-1:0] sel_req,
  input  logic            sel_park,
  output logic            sel_ready,
  output logic [N-1:0]    en_o,
  output logic [SELW-1:0] cur_sel,
  output logic            parked,
  output logic            busy,
  output logic            err
);
  if (!params_ok(N, DEAD_CYCLES, RST_SEL)) begin : g_bad_params
    $error("clk_sw_ctrl: parameter out of range");
  end
  state_t          r_state;
  logic [SELW-1:0] r_tgt;
  logic            r_tgt_park;
  logic            w_ill;
  logic            w_go;
  logic            w_load;
  logic            w_done;
  assign sel_ready = r_state != ST_DRAIN;
  assign w_ill = !sel_park && int'(sel_req) >= N;
  // Park only leaves RUN; a channel select from PARK always drains, even for cur_sel
  assign w_go = sel_park ? r_state == ST_RUN : (r_state == ST_PARK || sel_req != cur_sel);
  assign w_load = sel_ready && sel_valid && !w_ill && w_go;
  clk_sw_deadcnt #(.DEAD_CYCLES(DEAD_CYCLES)) u_deadcnt (
    .clk(clk),
    .rst(rst),
    .i_load(w_load),
    .i_dec(r_state == ST_DRAIN),
    .o_done(w_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= ST_RUN;
      r_tgt      <= SELW'(RST_SEL);
      r_tgt_park <= 1'b0;
      en_o       <= N'(onehot(4'(RST_SEL)));
      cur_sel    <= SELW'(RST_SEL);
      parked     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= sel_ready && sel_valid && w_ill;
      if (r_state == ST_DRAIN) begin
        if (w_done) begin
          busy    <= 1'b0;
          r_state <= r_tgt_park ? ST_PARK : ST_RUN;
          parked  <= r_tgt_park;
          if (!r_tgt_park) begin
            en_o    <= N'(onehot(4'(r_tgt)));
            cur_sel <= r_tgt;
          end
        end
      end else if (w_load) begin
        r_state    <= ST_DRAIN;
        r_tgt      <= sel_req;
        r_tgt_park <= sel_park;
        en_o       <= '0;
        busy       <= 1'b1;
        parked     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_clk_sw_ctrl.sv
// tb_clk_sw_ctrl: directed and randomized self-checking bench for clk_sw_ctrl
module tb_clk_sw_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, a_park = 1'b0;
  logic [1:0] a_req = '0;
  logic a_ready, a_parked, a_busy, a_err;
  logic [3:0] a_en;
  logic [1:0] a_cur;
  logic b_valid = 1'b0, b_park = 1'b0;
  logic [2:0] b_req = '0;
  logic b_ready, b_parked, b_busy, b_err;
  logic [4:0] b_en;
  logic [2:0] b_cur;
  int npass = 0;
  int ntotal = 0;
  always #5 clk = ~clk;
  clk_sw_ctrl #(.N(4), .DEAD_CYCLES(2), .RST_SEL(2)) u_a (
    .clk(clk), .rst(rst), .sel_valid(a_valid), .sel_req(a_req), .sel_park(a_park),
    .sel_ready(a_ready), .en_o(a_en), .cur_sel(a_cur), .parked(a_parked), .busy(a_busy), .err(a_err)
  );
  clk_sw_ctrl #(.N(5), .DEAD_CYCLES(2), .RST_SEL(0)) u_b (
    .clk(clk), .rst(rst), .sel_valid(b_valid), .sel_req(b_req), .sel_park(b_park),
    .sel_ready(b_ready), .en_o(b_en), .cur_sel(b_cur), .parked(b_parked), .busy(b_busy), .err(b_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] last;
    int zr;
    step;
    step;
    chk("rst_en", a_en, 4'b0100);
    chk("rst_cur", a_cur, 2);
    chk("rst_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_parked", a_parked, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b0;
    step;
    a_valid = 1'b1; a_req = 2'd0;
    step;
    a_valid = 1'b0;
    chk("sw_t1_en", a_en, 0);
    chk("sw_t1_busy", a_busy, 1);
    chk("sw_t1_ready", a_ready, 0);
    step;
    chk("sw_t2_en", a_en, 0);
    chk("sw_t2_busy", a_busy, 1);
    step;
    chk("sw_t3_en", a_en, 4'b0001);
    chk("sw_t3_cur", a_cur, 0);
    chk("sw_t3_busy", a_busy, 0);
    chk("sw_t3_ready", a_ready, 1);
    a_valid = 1'b1; a_req = 2'd0;
    step;
    a_valid = 1'b0;
    chk("same_en", a_en, 4'b0001);
    chk("same_busy", a_busy, 0);
    step;
    chk("same_en2", a_en, 4'b0001);
    a_valid = 1'b1; a_park = 1'b1; a_req = 2'd3;
    step;
    a_valid = 1'b0; a_park = 1'b0;
    chk("park_t1_en", a_en, 0);
    chk("park_t1_busy", a_busy, 1);
    step;
    chk("park_t2_parked", a_parked, 0);
    step;
    chk("park_t3_parked", a_parked, 1);
    chk("park_t3_en", a_en, 0);
    chk("park_t3_busy", a_busy, 0);
    chk("park_t3_ready", a_ready, 1);
    a_valid = 1'b1; a_park = 1'b1;
    step;
    a_valid = 1'b0; a_park = 1'b0;
    chk("repark_busy", a_busy, 0);
    chk("repark_parked", a_parked, 1);
    a_valid = 1'b1; a_req = 2'd1;
    step;
    a_valid = 1'b0;
    chk("unpark_t1_busy", a_busy, 1);
    chk("unpark_t1_en", a_en, 0);
    step;
    chk("unpark_t2_busy", a_busy, 1);
    step;
    chk("unpark_t3_en", a_en, 4'b0010);
    chk("unpark_t3_parked", a_parked, 0);
    chk("unpark_t3_cur", a_cur, 1);
    a_valid = 1'b1; a_req = 2'd3;
    step;
    a_req = 2'd0;
    chk("bp_t1_en", a_en, 0);
    step;
    chk("bp_t2_busy", a_busy, 1);
    step;
    chk("bp_t3_en", a_en, 4'b1000);
    chk("bp_t3_cur", a_cur, 3);
    step;
    a_valid = 1'b0;
    chk("bp_t4_en", a_en, 0);
    chk("bp_t4_busy", a_busy, 1);
    step;
    step;
    chk("bp_t6_en", a_en, 4'b0001);
    chk("bp_t6_cur", a_cur, 0);
    a_valid = 1'b1; a_req = 2'd1;
    step;
    a_valid = 1'b0;
    chk("mrst_drain_en", a_en, 0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_en", a_en, 4'b0100);
    chk("mrst_cur", a_cur, 2);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_ready", a_ready, 1);
    a_valid = 1'b1; a_req = 2'd0;
    step;
    a_valid = 1'b0;
    chk("rstreq_en", a_en, 4'b0100);
    chk("rstreq_busy", a_busy, 0);
    rst = 1'b0;
    step;
    chk("post_rst_en", a_en, 4'b0100);
    chk("post_rst_busy", a_busy, 0);
    chk("b_rst_en", b_en, 5'b00001);
    b_valid = 1'b1; b_req = 3'd5;
    step;
    b_valid = 1'b0;
    chk("ill5_err", b_err, 1);
    chk("ill5_en", b_en, 5'b00001);
    chk("ill5_busy", b_busy, 0);
    chk("ill5_cur", b_cur, 0);
    chk("ill5_ready", b_ready, 1);
    step;
    chk("ill5_err_clr", b_err, 0);
    chk("ill5_en2", b_en, 5'b00001);
    b_valid = 1'b1; b_req = 3'd7;
    step;
    b_valid = 1'b0;
    chk("ill7_err", b_err, 1);
    step;
    chk("ill7_err_clr", b_err, 0);
    b_valid = 1'b1; b_req = 3'd4;
    step;
    b_valid = 1'b0;
    chk("b_legal4_err", b_err, 0);
    chk("b_legal4_busy", b_busy, 1);
    step;
    step;
    chk("b_legal4_en", b_en, 5'b10000);
    last = a_en;
    zr = 0;
    for (int i = 0; i < 10000; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_req = 2'($urandom_range(0, 3));
      a_park = $urandom_range(0, 7) == 0;
      step;
      chk("rnd_onehot", 32'($countones(a_en) <= 1), 1);
      chk("rnd_ready", a_ready, !a_busy);
      if (a_en != 0) begin
        if (last != 0 && a_en != last) chk("rnd_gap", 32'(zr >= 2), 1);
        last = a_en;
        zr = 0;
      end else zr++;
    end
    a_valid = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
